// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_sched
//  Description : Write-back scheduler and scoreboard for a 32x32 register
//                file. Round-robin arbitration of the single register-file
//                write port between ALU, load and mul/div producers. Tracks
//                outstanding writes per register and stalls issue on RAW or
//                counter-saturation hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  // issue stage
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic            issue_rs1_used,
  input  logic            issue_rs2_used,
  input  logic            issue_wen,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  // ALU write-back
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  // load-unit write-back
  input  logic            mem_wb_valid,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,
  // mul/div write-back
  input  logic            md_wb_valid,
  input  logic [4:0]      md_wb_rd,
  input  logic [XLEN-1:0] md_wb_data,
  output logic            md_wb_ready,
  // pipeline control
  input  logic            flush,
  // register-file write port
  output logic            rf_we,
  output logic [4:0]      rf_rw,
  output logic [XLEN-1:0] rf_busw,
  // status
  output logic            pending_any,
  output logic            sb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = '0;

  // Round-robin pointer encoding
  localparam logic [1:0] PTR_ALU = 2'd0;
  localparam logic [1:0] PTR_MEM = 2'd1;
  localparam logic [1:0] PTR_MD  = 2'd2;

  logic [PEND_W-1:0] pend     [32];
  logic [PEND_W-1:0] pend_nxt [32];
  logic [31:0]       inc_vec;
  logic [31:0]       dec_vec;
  logic              err_set;

  logic [1:0]        ptr;
  logic              rf_stale;   // current rf_we came from a flush-cycle handshake

  logic [2:0]        req;        // {md, mem, alu}
  logic [2:0]        grant;
  logic              hs;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic              rs1_haz;
  logic              rs2_haz;
  logic              rd_haz;
  logic              accept;
  logic              retire;

  // ------------------------------------------------------------------------
  // Issue hazard detection (always on current registered scoreboard)
  // ------------------------------------------------------------------------
  assign rs1_haz = issue_rs1_used && (issue_rs1 != 5'd0) && (pend[issue_rs1] != PEND_ZERO);
  assign rs2_haz = issue_rs2_used && (issue_rs2 != 5'd0) && (pend[issue_rs2] != PEND_ZERO);
  assign rd_haz  = issue_wen && (issue_rd != 5'd0) && (pend[issue_rd] == PEND_MAX);

  assign issue_stall = issue_valid && (rs1_haz || rs2_haz || rd_haz);
  assign accept      = issue_valid && !issue_stall;

  // A write that was handshaken during a flush must not retire a counter
  // that the flush already cleared.
  assign retire  = rf_we && !rf_stale;

  assign inc_vec = (accept && issue_wen && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
  assign dec_vec = (retire && (rf_rw != 5'd0)) ? (32'd1 << rf_rw) : 32'd0;

  // ------------------------------------------------------------------------
  // Write-back arbitration
  // ------------------------------------------------------------------------
  assign req = rst ? 3'b000 : {md_wb_valid, mem_wb_valid, alu_wb_valid};

  // Rotating-priority grant: the producer at ptr is checked first
  always_comb begin
    grant = 3'b000;
    case (ptr)
      PTR_MEM: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      PTR_MD: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  assign alu_wb_ready = grant[0];
  assign mem_wb_ready = grant[1];
  assign md_wb_ready  = grant[2];
  assign hs           = |grant;

  // Select destination and data of the granted producer
  always_comb begin
    sel_rd   = 5'd0;
    sel_data = '0;
    if (grant[0]) begin
      sel_rd   = alu_wb_rd;
      sel_data = alu_wb_data;
    end else if (grant[1]) begin
      sel_rd   = mem_wb_rd;
      sel_data = mem_wb_data;
    end else if (grant[2]) begin
      sel_rd   = md_wb_rd;
      sel_data = md_wb_data;
    end
  end

  // ------------------------------------------------------------------------
  // Scoreboard next-state
  // ------------------------------------------------------------------------
  // Per-register counter update; flush wins, coincident inc/dec cancel
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pend_nxt[i] = pend[i];
      if (i == 0 || flush) begin
        pend_nxt[i] = PEND_ZERO;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        if (pend[i] == PEND_MAX) err_set = 1'b1;
        else                     pend_nxt[i] = pend[i] + PEND_ONE;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (pend[i] == PEND_ZERO) err_set = 1'b1;
        else                      pend_nxt[i] = pend[i] - PEND_ONE;
      end
    end
  end

  // Any register still awaiting a write-back
  always_comb begin
    pending_any = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (pend[i] != PEND_ZERO) pending_any = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  // Scoreboard counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) pend[i] <= PEND_ZERO;
      else     pend[i] <= pend_nxt[i];
    end
  end

  // Round-robin pointer advances past the granted producer
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr <= PTR_ALU;
    end else if (grant[0]) begin
      ptr <= PTR_MEM;
    end else if (grant[1]) begin
      ptr <= PTR_MD;
    end else if (grant[2]) begin
      ptr <= PTR_ALU;
    end
  end

  // Register-file write port: one-cycle pulse per granted non-x0 result
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rw    <= 5'd0;
      rf_busw  <= '0;
      rf_stale <= 1'b0;
    end else begin
      rf_we    <= hs && (sel_rd != 5'd0);
      rf_stale <= flush;
      if (hs) begin
        rf_rw   <= sel_rd;
        rf_busw <= sel_data;
      end
    end
  end

  // Sticky scoreboard error on counter underflow or overflow
  always_ff @(posedge clk) begin
    if (rst)          sb_err <= 1'b0;
    else if (err_set) sb_err <= 1'b1;
  end

endmodule
`default_nettype wire
